lsu_arbiter: RTL and testbench
==============================

Name: lsu_arbiter

Overview:
- Shares the single load/store unit port between two requesters:
  - the pipeline MEM stage ("core", C);
  - the debug/program-loader port ("debug", D).
- Sits between those requesters and the LSU.
- Latches the winning request, sequences the LSU write or read strobe for the configured load latency, and returns load data to the owning requester.
- Fixed core priority, with a starvation guard so the debug port is guaranteed progress.

Parameters:
- LD_LATENCY, 1: cycles o_lsu_rden is held before i_lsu_ld_data is sampled; legal range 1..3.
- STARVE_MAX, 4: consecutive core grants allowed while i_d_req is pending before debug is forced to win; legal range 1..15.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset; synchronous, active-low.
- i_c_req  in  1  core request; held with stable fields until o_c_gnt.
- i_c_wren  in  1  1 = store, 0 = load.
- i_c_addr  in  32  byte address.
- i_c_wdata  in  32  store data.
- i_c_func3  in  3  access size/sign code (RV32 load/store func3).
- o_c_gnt  out  1  one-cycle pulse: core request accepted.
- o_c_rvalid  out  1  one-cycle pulse: o_c_rdata valid.
- o_c_rdata  out  32  load data.
- o_c_stall  out  1  i_c_req & ~o_c_gnt (combinational).
- i_d_req, i_d_wren, i_d_addr[31:0], i_d_wdata[31:0], i_d_func3[2:0]  in  same as core.
- o_d_gnt, o_d_rvalid, o_d_rdata[31:0]  out  same as core.
- o_lsu_addr  out  32  to LSU.
- o_lsu_st_data  out  32  to LSU.
- o_lsu_func3  out  3  to LSU.
- o_lsu_wren  out  1  LSU write strobe.
- o_lsu_rden  out  1  LSU read strobe.
- i_lsu_ld_data  in  32  LSU load data.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset (i_reset = 0 at a rising edge):
  - state = IDLE, starvation counter = 0, latency counter = 0.
  - o_c_rdata, o_d_rdata, o_lsu_addr, o_lsu_st_data = 0; o_lsu_func3 = 0.
  - All strobes, gnt and rvalid = 0.
- Reset mid-transaction abandons it: no rvalid is issued and no further strobe is driven.
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - Arbitration is evaluated combinationally from the requests; o_X_gnt pulses in the same cycle for the winner.
  - The winner's addr/wdata/func3/wren and owner id are registered; next state is ISSUE.
  - No request: stay in IDLE.
- Arbitration rule:
  - Debug wins if i_d_req is set and either i_c_req = 0 or starve_cnt == STARVE_MAX.
  - Otherwise core wins when i_c_req = 1.
- Starvation counter:
  - Increments on a core grant while i_d_req = 1, saturating at STARVE_MAX.
  - Clears on a debug grant or whenever i_d_req = 0.
- ISSUE, store:
  - o_lsu_wren = 1 for exactly one cycle, with the latched fields on the o_lsu_* outputs.
  - Next state is IDLE, so store throughput is one per 2 cycles.
- ISSUE, load:
  - o_lsu_rden = 1 and the latency counter is loaded with LD_LATENCY-1.
  - If LD_LATENCY = 1: sample i_lsu_ld_data this cycle and go to IDLE.
  - Otherwise go to WAIT_RD.
- WAIT_RD:
  - o_lsu_rden stays 1 and the address is held stable.
  - The counter decrements each cycle.
  - When the counter reaches 0: sample i_lsu_ld_data at that edge, then go to IDLE.
- Load response:
  - Captured data is written into the owner's rdata register.
  - o_X_rvalid pulses in the cycle after capture; this coincides with IDLE, where a new grant is allowed in the same cycle.
  - The non-owner's rdata register is unchanged.
- Load timing (LD_LATENCY = L, grant in cycle N): rden high in N+1 .. N+L; rvalid in N+L+1.
- Strobe exclusivity: o_lsu_wren and o_lsu_rden are never both 1, and both are 0 in IDLE.
- Request inputs are ignored outside IDLE; gnt never pulses outside IDLE.
- func3 is forwarded unchanged; illegal codes are handled by the LSU.

Decomposition:
- Package lsu_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT_RD);
  - owner enum (OWN_CORE, OWN_DBG);
  - func3 constants (LB = 000, LH = 001, LW = 010, LBU = 100, LHU = 101).
- One sub-module, lsu_arb_pick:
  - combinational winner select from the two requests and starve_cnt;
  - owns the saturating starvation counter register.

Test Plan:
- Core LW, LD_LATENCY = 1, addr 0x0000_0010, LSU returns 0xDEADBEEF:
  - gnt at N; rden only at N+1; o_c_rvalid = 1 with o_c_rdata = 0xDEADBEEF at N+2;
  - o_d_rvalid stays 0.
- Core SW to 0x1000_0000, wdata 0x0000_00FF, func3 = 010:
  - wren at N+1 only, o_lsu_addr = 0x1000_0000, o_lsu_st_data = 0xFF;
  - o_busy = 0 at N+2.
- Core and debug request simultaneously with stores:
  - core granted at N, debug at N+2;
  - o_c_stall = 0 throughout, since the core request drops after its grant.
- Core requests continuously, debug pending, STARVE_MAX = 4:
  - core granted at 4 arbitrations; 5th grant goes to debug;
  - counter is 0 afterwards.
- LD_LATENCY = 3, debug LBU at 0x1001_0000, LSU returns 0x0000_0005:
  - rden held N+1..N+3 with stable address;
  - o_d_rvalid = 1 with o_d_rdata = 0x5 at N+4.
- LD_LATENCY = 3, reset asserted at N+2 during WAIT_RD:
  - at N+3: state = IDLE, no rvalid, strobes 0;
  - a new core request after reset is granted normally.

Source files
------------

// File: rtl/lsu_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_arb_pkg
//  Purpose  : Shared constants for the LSU arbiter (FSM states, owner ids,
//             RV32 load/store func3 codes).
//  Revision : 1.0  initial release
// ============================================================================
package lsu_arb_pkg;

  // Arbiter FSM state encoding
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT_RD = 2'd2;

  // Owner of the in-flight transaction
  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DBG  = 1'b1;

  // RV32 load/store size/sign codes (forwarded untouched to the LSU)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage
`default_nettype wire

// File: rtl/lsu_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_arb_pick
//  Purpose  : Core-priority winner select with a saturating starvation
//             counter that forces the debug port through after STARVE_MAX
//             consecutive core wins while debug is waiting.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_arb_pick
  import lsu_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_arb_en,
  input  logic i_c_req,
  input  logic i_d_req,
  output logic o_pick_c,
  output logic o_pick_d
);

  localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

  logic [3:0] r_starve_cnt;
  logic       w_d_win;

  // Debug wins when core is quiet or when debug has waited long enough
  always_comb begin
    w_d_win  = i_d_req & (~i_c_req | (r_starve_cnt == C_STARVE_MAX));
    o_pick_d = i_arb_en & w_d_win;
    o_pick_c = i_arb_en & i_c_req & ~w_d_win;
  end

  // Count core wins that overtook a pending debug request, saturating
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_starve_cnt <= 4'd0;
    end else if (!i_d_req || o_pick_d) begin
      r_starve_cnt <= 4'd0;
    end else if (o_pick_c && (r_starve_cnt != C_STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lsu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_arbiter
//  Purpose  : Shares one LSU port between the core MEM stage and the debug
//             loader port. Latches the winner, drives the write or read
//             strobe for the configured load latency and routes load data
//             back to the owning requester.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int LD_LATENCY = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_c_req,
  input  logic        i_c_wren,
  input  logic [31:0] i_c_addr,
  input  logic [31:0] i_c_wdata,
  input  logic [2:0]  i_c_func3,
  output logic        o_c_gnt,
  output logic        o_c_rvalid,
  output logic [31:0] o_c_rdata,
  output logic        o_c_stall,
  input  logic        i_d_req,
  input  logic        i_d_wren,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [2:0]  i_d_func3,
  output logic        o_d_gnt,
  output logic        o_d_rvalid,
  output logic [31:0] o_d_rdata,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_lsu_st_data,
  output logic [2:0]  o_lsu_func3,
  output logic        o_lsu_wren,
  output logic        o_lsu_rden,
  input  logic [31:0] i_lsu_ld_data,
  output logic        o_busy
);

  localparam logic [1:0] C_LAT_INIT = 2'(LD_LATENCY - 1);

  logic [1:0]  r_state;
  logic        r_owner;
  logic        r_wren;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_func3;
  logic [1:0]  r_lat_cnt;
  logic [31:0] r_c_rdata;
  logic [31:0] r_d_rdata;
  logic        r_c_rvalid;
  logic        r_d_rvalid;

  logic        w_arb_en;
  logic        w_pick_c;
  logic        w_pick_d;
  logic        w_capture;

  assign w_arb_en = (r_state == S_IDLE);

  lsu_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_arb_en (w_arb_en),
    .i_c_req  (i_c_req),
    .i_d_req  (i_d_req),
    .o_pick_c (w_pick_c),
    .o_pick_d (w_pick_d)
  );

  // Strobes, grants and load-capture timing derived from the current state
  always_comb begin
    o_c_gnt       = w_pick_c;
    o_d_gnt       = w_pick_d;
    o_c_stall     = i_c_req & ~w_pick_c;
    o_lsu_wren    = (r_state == S_ISSUE) & r_wren;
    o_lsu_rden    = ((r_state == S_ISSUE) & ~r_wren) | (r_state == S_WAIT_RD);
    o_lsu_addr    = r_addr;
    o_lsu_st_data = r_wdata;
    o_lsu_func3   = r_func3;
    o_busy        = (r_state != S_IDLE);
    o_c_rvalid    = r_c_rvalid;
    o_d_rvalid    = r_d_rvalid;
    o_c_rdata     = r_c_rdata;
    o_d_rdata     = r_d_rdata;
    w_capture     = ((r_state == S_ISSUE) & ~r_wren & (LD_LATENCY == 1)) |
                    ((r_state == S_WAIT_RD) & (r_lat_cnt <= 2'd1));
  end

  // Transaction FSM: latch the winner, then issue and wait out the load
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= S_IDLE;
      r_owner   <= OWN_CORE;
      r_wren    <= 1'b0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_func3   <= 3'd0;
      r_lat_cnt <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_c || w_pick_d) begin
            r_owner <= w_pick_d ? OWN_DBG : OWN_CORE;
            r_wren  <= w_pick_d ? i_d_wren  : i_c_wren;
            r_addr  <= w_pick_d ? i_d_addr  : i_c_addr;
            r_wdata <= w_pick_d ? i_d_wdata : i_c_wdata;
            r_func3 <= w_pick_d ? i_d_func3 : i_c_func3;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_wren) begin
            r_state <= S_IDLE;
          end else begin
            r_lat_cnt <= C_LAT_INIT;
            r_state   <= (LD_LATENCY == 1) ? S_IDLE : S_WAIT_RD;
          end
        end
        S_WAIT_RD: begin
          if (r_lat_cnt <= 2'd1) begin
            r_lat_cnt <= 2'd0;
            r_state   <= S_IDLE;
          end else begin
            r_lat_cnt <= r_lat_cnt - 2'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Route captured load data to the owner and pulse its rvalid next cycle
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_c_rdata  <= 32'd0;
      r_d_rdata  <= 32'd0;
      r_c_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
    end else begin
      r_c_rvalid <= w_capture & (r_owner == OWN_CORE);
      r_d_rvalid <= w_capture & (r_owner == OWN_DBG);
      if (w_capture && (r_owner == OWN_CORE)) r_c_rdata <= i_lsu_ld_data;
      if (w_capture && (r_owner == OWN_DBG))  r_d_rdata <= i_lsu_ld_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_arbiter
//  Purpose  : Directed self-checking bench for lsu_arbiter. Two instances
//             share stimulus: dut1 (LD_LATENCY=1) and dut3 (LD_LATENCY=3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_wren, d_req, d_wren;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata, ld_data;
  logic [2:0]  c_func3, d_func3;

  logic        c_gnt1, c_rvalid1, c_stall1, d_gnt1, d_rvalid1, wren1, rden1, busy1;
  logic [31:0] c_rdata1, d_rdata1, lsu_addr1, st_data1;
  logic [2:0]  func3_1;
  logic        c_gnt3, c_rvalid3, c_stall3, d_gnt3, d_rvalid3, wren3, rden3, busy3;
  logic [31:0] c_rdata3, d_rdata3, lsu_addr3, st_data3;
  logic [2:0]  func3_3;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_arbiter #(.LD_LATENCY(1), .STARVE_MAX(4)) dut1 (
    .i_clk(clk), .i_reset(rst_n),
    .i_c_req(c_req), .i_c_wren(c_wren), .i_c_addr(c_addr), .i_c_wdata(c_wdata), .i_c_func3(c_func3),
    .o_c_gnt(c_gnt1), .o_c_rvalid(c_rvalid1), .o_c_rdata(c_rdata1), .o_c_stall(c_stall1),
    .i_d_req(d_req), .i_d_wren(d_wren), .i_d_addr(d_addr), .i_d_wdata(d_wdata), .i_d_func3(d_func3),
    .o_d_gnt(d_gnt1), .o_d_rvalid(d_rvalid1), .o_d_rdata(d_rdata1),
    .o_lsu_addr(lsu_addr1), .o_lsu_st_data(st_data1), .o_lsu_func3(func3_1),
    .o_lsu_wren(wren1), .o_lsu_rden(rden1), .i_lsu_ld_data(ld_data), .o_busy(busy1)
  );

  lsu_arbiter #(.LD_LATENCY(3), .STARVE_MAX(4)) dut3 (
    .i_clk(clk), .i_reset(rst_n),
    .i_c_req(c_req), .i_c_wren(c_wren), .i_c_addr(c_addr), .i_c_wdata(c_wdata), .i_c_func3(c_func3),
    .o_c_gnt(c_gnt3), .o_c_rvalid(c_rvalid3), .o_c_rdata(c_rdata3), .o_c_stall(c_stall3),
    .i_d_req(d_req), .i_d_wren(d_wren), .i_d_addr(d_addr), .i_d_wdata(d_wdata), .i_d_func3(d_func3),
    .o_d_gnt(d_gnt3), .o_d_rvalid(d_rvalid3), .o_d_rdata(d_rdata3),
    .o_lsu_addr(lsu_addr3), .o_lsu_st_data(st_data3), .o_lsu_func3(func3_3),
    .o_lsu_wren(wren3), .o_lsu_rden(rden3), .i_lsu_ld_data(ld_data), .o_busy(busy3)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    c_req = 0; c_wren = 0; c_addr = 0; c_wdata = 0; c_func3 = 0;
    d_req = 0; d_wren = 0; d_addr = 0; d_wdata = 0; d_func3 = 0;
    ld_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    cyc(); cyc();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    cyc(); cyc();
    #1;
    n_run++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %h expected 0", busy1); end
    n_run++; if ({wren1, rden1, c_gnt1, d_gnt1, c_rvalid1, d_rvalid1} !== 6'b0) begin n_fail++; $display("FAIL rst_strobes: got %b expected 000000", {wren1, rden1, c_gnt1, d_gnt1, c_rvalid1, d_rvalid1}); end
    n_run++; if (c_rdata1 !== 32'd0 || d_rdata1 !== 32'd0) begin n_fail++; $display("FAIL rst_rdata: got %h/%h expected 0/0", c_rdata1, d_rdata1); end
    n_run++; if (lsu_addr1 !== 32'd0 || st_data1 !== 32'd0 || func3_1 !== 3'd0) begin n_fail++; $display("FAIL rst_lsu: got %h/%h/%h expected 0/0/0", lsu_addr1, st_data1, func3_1); end
    n_run++; if (busy3 !== 1'b0 || rden3 !== 1'b0) begin n_fail++; $display("FAIL rst_dut3: got %h/%h expected 0/0", busy3, rden3); end
    rst_n = 1;
  endtask

  task automatic test_core_load_lat1();
    do_reset();
    c_req = 1; c_wren = 0; c_addr = 32'h0000_0010; c_func3 = 3'b010;
    #1;
    n_run++; if (c_gnt1 !== 1'b1 || rden1 !== 1'b0) begin n_fail++; $display("FAIL lw_gnt: got gnt=%h rden=%h expected 1/0", c_gnt1, rden1); end
    cyc(); c_req = 0; ld_data = 32'hDEAD_BEEF; #1;
    n_run++; if (rden1 !== 1'b1 || wren1 !== 1'b0 || lsu_addr1 !== 32'h10 || func3_1 !== 3'b010) begin n_fail++; $display("FAIL lw_rden: got rden=%h wren=%h addr=%h f3=%h expected 1/0/10/2", rden1, wren1, lsu_addr1, func3_1); end
    n_run++; if (c_rvalid1 !== 1'b0) begin n_fail++; $display("FAIL lw_early_rvalid: got %h expected 0", c_rvalid1); end
    // back-to-back: new grant in the rvalid cycle
    cyc(); ld_data = 32'h0; c_req = 1; c_addr = 32'h0000_0014; #1;
    n_run++; if (c_rvalid1 !== 1'b1 || c_rdata1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_rvalid: got v=%h d=%h expected 1/deadbeef", c_rvalid1, c_rdata1); end
    n_run++; if (d_rvalid1 !== 1'b0 || d_rdata1 !== 32'd0 || rden1 !== 1'b0) begin n_fail++; $display("FAIL lw_dbg_quiet: got dv=%h dd=%h rden=%h expected 0/0/0", d_rvalid1, d_rdata1, rden1); end
    n_run++; if (c_gnt1 !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt: got %h expected 1", c_gnt1); end
    cyc(); c_req = 0; ld_data = 32'h0BAD_F00D; #1;
    n_run++; if (rden1 !== 1'b1 || lsu_addr1 !== 32'h14 || c_rvalid1 !== 1'b0) begin n_fail++; $display("FAIL b2b_rden: got rden=%h addr=%h v=%h expected 1/14/0", rden1, lsu_addr1, c_rvalid1); end
    cyc(); #1;
    n_run++; if (c_rvalid1 !== 1'b1 || c_rdata1 !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL b2b_rvalid: got v=%h d=%h expected 1/0badf00d", c_rvalid1, c_rdata1); end
    cyc(); #1;
    n_run++; if (c_rvalid1 !== 1'b0) begin n_fail++; $display("FAIL rvalid_pulse: got %h expected 0", c_rvalid1); end
  endtask

  task automatic test_core_store();
    do_reset();
    c_req = 1; c_wren = 1; c_addr = 32'h1000_0000; c_wdata = 32'h0000_00FF; c_func3 = 3'b010;
    #1;
    n_run++; if (c_gnt1 !== 1'b1 || c_stall1 !== 1'b0 || wren1 !== 1'b0) begin n_fail++; $display("FAIL sw_gnt: got gnt=%h stall=%h wren=%h expected 1/0/0", c_gnt1, c_stall1, wren1); end
    cyc(); c_req = 0; #1;
    n_run++; if (wren1 !== 1'b1 || rden1 !== 1'b0 || busy1 !== 1'b1) begin n_fail++; $display("FAIL sw_wren: got wren=%h rden=%h busy=%h expected 1/0/1", wren1, rden1, busy1); end
    n_run++; if (lsu_addr1 !== 32'h1000_0000 || st_data1 !== 32'hFF || func3_1 !== 3'b010) begin n_fail++; $display("FAIL sw_fields: got %h/%h/%h expected 10000000/ff/2", lsu_addr1, st_data1, func3_1); end
    cyc(); #1;
    n_run++; if (busy1 !== 1'b0 || wren1 !== 1'b0 || c_rvalid1 !== 1'b0) begin n_fail++; $display("FAIL sw_done: got busy=%h wren=%h v=%h expected 0/0/0", busy1, wren1, c_rvalid1); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    c_req = 1; c_wren = 1; c_addr = 32'hA0; c_wdata = 32'h1; c_func3 = 3'b010;
    d_req = 1; d_wren = 1; d_addr = 32'hB0; d_wdata = 32'h2; d_func3 = 3'b000;
    #1;
    n_run++; if (c_gnt1 !== 1'b1 || d_gnt1 !== 1'b0 || c_stall1 !== 1'b0) begin n_fail++; $display("FAIL sim_n: got cg=%h dg=%h st=%h expected 1/0/0", c_gnt1, d_gnt1, c_stall1); end
    cyc(); c_req = 0; #1;
    n_run++; if (d_gnt1 !== 1'b0 || c_stall1 !== 1'b0 || wren1 !== 1'b1 || lsu_addr1 !== 32'hA0 || st_data1 !== 32'h1) begin n_fail++; $display("FAIL sim_n1: got dg=%h st=%h wren=%h addr=%h data=%h expected 0/0/1/a0/1", d_gnt1, c_stall1, wren1, lsu_addr1, st_data1); end
    cyc(); #1;
    n_run++; if (d_gnt1 !== 1'b1 || c_gnt1 !== 1'b0 || c_stall1 !== 1'b0) begin n_fail++; $display("FAIL sim_n2: got dg=%h cg=%h st=%h expected 1/0/0", d_gnt1, c_gnt1, c_stall1); end
    cyc(); d_req = 0; #1;
    n_run++; if (wren1 !== 1'b1 || lsu_addr1 !== 32'hB0 || st_data1 !== 32'h2 || func3_1 !== 3'b000) begin n_fail++; $display("FAIL sim_n3: got wren=%h addr=%h data=%h f3=%h expected 1/b0/2/0", wren1, lsu_addr1, st_data1, func3_1); end
  endtask

  task automatic test_starvation();
    do_reset();
    c_req = 1; c_wren = 1; c_addr = 32'h100; c_wdata = 32'h11; c_func3 = 3'b010;
    d_req = 1; d_wren = 1; d_addr = 32'h200; d_wdata = 32'h22; d_func3 = 3'b010;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_run++; if (dut1.u_pick.r_starve_cnt !== 4'(k)) begin n_fail++; $display("FAIL starve_cnt_%0d: got %0d expected %0d", k, dut1.u_pick.r_starve_cnt, k); end
      if (k < 4) begin
        n_run++; if (c_gnt1 !== 1'b1 || d_gnt1 !== 1'b0) begin n_fail++; $display("FAIL starve_core_%0d: got cg=%h dg=%h expected 1/0", k, c_gnt1, d_gnt1); end
      end else begin
        n_run++; if (d_gnt1 !== 1'b1 || c_gnt1 !== 1'b0 || c_stall1 !== 1'b1) begin n_fail++; $display("FAIL starve_dbg: got dg=%h cg=%h st=%h expected 1/0/1", d_gnt1, c_gnt1, c_stall1); end
      end
      cyc();
      if (k == 4) begin
        d_req = 0; #1;
        n_run++; if (dut1.u_pick.r_starve_cnt !== 4'd0) begin n_fail++; $display("FAIL starve_clear: got %0d expected 0", dut1.u_pick.r_starve_cnt); end
        n_run++; if (wren1 !== 1'b1 || lsu_addr1 !== 32'h200 || st_data1 !== 32'h22) begin n_fail++; $display("FAIL starve_dbg_store: got wren=%h addr=%h data=%h expected 1/200/22", wren1, lsu_addr1, st_data1); end
      end
      cyc();
    end
    c_req = 0;
  endtask

  task automatic test_debug_load_lat3();
    do_reset();
    d_req = 1; d_wren = 0; d_addr = 32'h1001_0000; d_func3 = 3'b100;
    #1;
    n_run++; if (d_gnt3 !== 1'b1 || c_gnt3 !== 1'b0) begin n_fail++; $display("FAIL lbu_gnt: got dg=%h cg=%h expected 1/0", d_gnt3, c_gnt3); end
    cyc(); d_req = 0; ld_data = 32'h0000_0005;
    for (int i = 1; i <= 3; i++) begin
      #1;
      n_run++; if (rden3 !== 1'b1 || wren3 !== 1'b0 || lsu_addr3 !== 32'h1001_0000 || func3_3 !== 3'b100 || d_rvalid3 !== 1'b0) begin n_fail++; $display("FAIL lbu_wait_%0d: got rden=%h wren=%h addr=%h f3=%h v=%h expected 1/0/10010000/4/0", i, rden3, wren3, lsu_addr3, func3_3, d_rvalid3); end
      cyc();
    end
    #1;
    n_run++; if (d_rvalid3 !== 1'b1 || d_rdata3 !== 32'h5 || rden3 !== 1'b0) begin n_fail++; $display("FAIL lbu_rvalid: got v=%h d=%h rden=%h expected 1/5/0", d_rvalid3, d_rdata3, rden3); end
    n_run++; if (c_rvalid3 !== 1'b0 || c_rdata3 !== 32'd0) begin n_fail++; $display("FAIL lbu_core_quiet: got v=%h d=%h expected 0/0", c_rvalid3, c_rdata3); end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    c_req = 1; c_wren = 0; c_addr = 32'h40; c_func3 = 3'b010; ld_data = 32'hCAFE_0001;
    #1;
    n_run++; if (c_gnt3 !== 1'b1) begin n_fail++; $display("FAIL mid_gnt: got %h expected 1", c_gnt3); end
    cyc(); c_req = 0;
    cyc(); #1;
    n_run++; if (rden3 !== 1'b1 || busy3 !== 1'b1) begin n_fail++; $display("FAIL mid_wait: got rden=%h busy=%h expected 1/1", rden3, busy3); end
    rst_n = 0;
    cyc(); rst_n = 1; #1;
    n_run++; if (busy3 !== 1'b0 || rden3 !== 1'b0 || wren3 !== 1'b0 || c_rvalid3 !== 1'b0) begin n_fail++; $display("FAIL mid_abort: got busy=%h rden=%h wren=%h v=%h expected 0/0/0/0", busy3, rden3, wren3, c_rvalid3); end
    cyc(); #1;
    n_run++; if (c_rvalid3 !== 1'b0 || rden3 !== 1'b0 || c_rdata3 !== 32'd0) begin n_fail++; $display("FAIL mid_no_rvalid: got v=%h rden=%h d=%h expected 0/0/0", c_rvalid3, rden3, c_rdata3); end
    c_req = 1; c_addr = 32'h44; ld_data = 32'h1234_5678; #1;
    n_run++; if (c_gnt3 !== 1'b1) begin n_fail++; $display("FAIL post_rst_gnt: got %h expected 1", c_gnt3); end
    cyc(); c_req = 0;
    cyc(); cyc(); cyc(); #1;
    n_run++; if (c_rvalid3 !== 1'b1 || c_rdata3 !== 32'h1234_5678) begin n_fail++; $display("FAIL post_rst_load: got v=%h d=%h expected 1/12345678", c_rvalid3, c_rdata3); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    cyc();
    test_reset();
    test_core_load_lat1();
    test_core_store();
    test_simultaneous();
    test_starvation();
    test_debug_load_lat3();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
